// File: rtl/vs_countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload terminal-count pulse.
// Latency: first decrement one edge after entering RUN; tc_pulse registered, L edges after RUN entry.
// Backpressure: load_ready drops while running; a pending load is held by the producer, never dropped.
module vs_countdown_timer #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_value,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    output logic [N-1:0] count,
    output logic         running,
    output logic         tc_pulse,
    output logic         expired
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] reload;
    logic         load_acc;
    logic [N-1:0] eff_count;

    // Loads are only taken while stopped; a same-cycle load feeds the start decision.
    assign load_ready = (state != S_RUN);
    assign running    = (state == S_RUN);
    assign load_acc   = load_valid & load_ready;
    assign eff_count  = load_acc ? load_value : count;

    // Timer state machine: load/start while stopped, decrement and terminal count while running.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            reload   <= '0;
            tc_pulse <= 1'b0;
            expired  <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            case (state)
                S_IDLE, S_PAUSED: begin
                    if (load_acc) begin
                        count   <= load_value;
                        reload  <= load_value;
                        expired <= 1'b0;
                    end
                    // Never enter RUN with a zero count, so the decrement cannot wrap.
                    if (start && !stop && (eff_count != '0)) begin
                        state   <= S_RUN;
                        expired <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_PAUSED;
                    end else if (count > 1) begin
                        count <= count - 1'b1;
                    end else begin
                        // Terminal count; periodic is sampled live here, not latched at start.
                        tc_pulse <= 1'b1;
                        if (periodic) begin
                            count <= reload;
                        end else begin
                            count   <= '0;
                            expired <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vs_countdown_timer.sv
module tb_vs_countdown_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_value;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] count;
    logic       running;
    logic       tc_pulse;
    logic       expired;

    int checks   = 0;
    int failures = 0;

    // Reference model: a timer is either running or not; stopped-idle and
    // stopped-paused behave identically from the outside.
    int m_cnt;
    int m_rel;
    bit m_run;
    bit m_tc;
    bit m_exp;

    vs_countdown_timer #(.N(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .count      (count),
        .running    (running),
        .tc_pulse   (tc_pulse),
        .expired    (expired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the spec's rules on the given inputs.
    task automatic model_step(input bit r, input bit lv, input int v, input bit st,
                              input bit sp, input bit per);
        if (r) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0; m_exp = 0;
            return;
        end
        m_tc = 0;
        if (!m_run) begin
            if (lv) begin
                m_cnt = v; m_rel = v; m_exp = 0;
            end
            if (st && !sp && m_cnt != 0) begin
                m_run = 1; m_exp = 0;
            end
        end else if (sp) begin
            m_run = 0;
        end else if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
        end else begin
            m_tc = 1;
            if (per) m_cnt = m_rel;
            else begin
                m_cnt = 0; m_exp = 1; m_run = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare every output with the model.
    task automatic cyc(input bit r, input bit lv, input int v, input bit st,
                       input bit sp, input bit per);
        reset      = r;
        load_valid = lv;
        load_value = v[7:0];
        start      = st;
        stop       = sp;
        periodic   = per;
        #1;
        chk("load_ready_pre", {31'd0, load_ready}, {31'd0, !m_run});
        model_step(r, lv, v, st, sp, per);
        @(posedge clock);
        #1;
        chk("count",      {24'd0, count},      m_cnt);
        chk("running",    {31'd0, running},    {31'd0, m_run});
        chk("load_ready", {31'd0, load_ready}, {31'd0, !m_run});
        chk("tc_pulse",   {31'd0, tc_pulse},   {31'd0, m_tc});
        chk("expired",    {31'd0, expired},    {31'd0, m_exp});
    endtask

    task automatic idle_cyc(input bit per);
        cyc(0, 0, 0, 0, 0, per);
    endtask

    initial begin
        int n;
        int edges;
        bit seen;
        int v;
        m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0; m_exp = 0;
        reset = 1; load_valid = 0; load_value = 0; start = 0; stop = 0; periodic = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 1, 0, 1);
        chk("rst_count", {24'd0, count}, 0);
        chk("rst_ready", {31'd0, load_ready}, 1);

        // 1: one-shot load 5
        cyc(0, 1, 5, 1, 0, 0);
        chk("t1_start_count", {24'd0, count}, 5);
        for (int i = 0; i < 5; i++) idle_cyc(0);
        chk("t1_end_count", {24'd0, count}, 0);
        chk("t1_tc", {31'd0, tc_pulse}, 1);
        chk("t1_expired", {31'd0, expired}, 1);
        chk("t1_running", {31'd0, running}, 0);
        chk("t1_ready", {31'd0, load_ready}, 1);
        idle_cyc(0);
        chk("t1_tc_once", {31'd0, tc_pulse}, 0);
        chk("t1_expired_sticky", {31'd0, expired}, 1);

        // 2: periodic load 3, period of 3 cycles
        cyc(0, 1, 3, 1, 0, 1);
        chk("t2_expired_clr", {31'd0, expired}, 0);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            idle_cyc(1);
            if (tc_pulse) begin
                n++;
                chk("t2_tc_at_reload", {24'd0, count}, 3);
            end
        end
        chk("t2_pulses", n, 3);
        cyc(0, 0, 0, 0, 1, 1);

        // 3: pause after 3 decrements, then resume
        cyc(0, 1, 8, 1, 0, 0);
        for (int i = 0; i < 3; i++) idle_cyc(0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t3_held", {24'd0, count}, 5);
        chk("t3_ready", {31'd0, load_ready}, 1);
        idle_cyc(0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t3_held2", {24'd0, count}, 5);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3_resumed", {31'd0, running}, 1);
        edges = 0; seen = 0;
        while (!seen && edges < 20) begin
            idle_cyc(0);
            edges++;
            seen = tc_pulse;
        end
        chk("t3_tc_edges", edges, 5);

        // 4: load 0 with start is ignored; periodic reload 1 pulses every cycle
        cyc(0, 1, 0, 1, 0, 0);
        chk("t4_zero_count", {24'd0, count}, 0);
        chk("t4_zero_run", {31'd0, running}, 0);
        chk("t4_zero_tc", {31'd0, tc_pulse}, 0);
        cyc(0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1);
            chk("t4_tc_every", {31'd0, tc_pulse}, 1);
            chk("t4_count1", {24'd0, count}, 1);
        end
        cyc(0, 0, 0, 0, 1, 1);

        // 5: load refused while running; stop beats terminal count
        cyc(0, 1, 2, 1, 0, 0);
        cyc(0, 1, 99, 0, 0, 0);
        chk("t5_ignored_load", {24'd0, count}, 1);
        chk("t5_busy", {31'd0, load_ready}, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t5_paused_count", {24'd0, count}, 1);
        chk("t5_no_tc", {31'd0, tc_pulse}, 0);
        chk("t5_paused", {31'd0, running}, 0);

        // 6: reset mid-run at count 4 aborts without a pulse
        cyc(0, 1, 9, 1, 0, 0);
        for (int i = 0; i < 5; i++) idle_cyc(0);
        chk("t6_at4", {24'd0, count}, 4);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 6, 1, 0, 1);
            chk("t6_count", {24'd0, count}, 0);
            chk("t6_tc", {31'd0, tc_pulse}, 0);
            chk("t6_run", {31'd0, running}, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0:       v = 255;
                1:       v = $urandom_range(0, 1);
                default: v = $urandom_range(0, 12);
            endcase
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) == 0),
                v,
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vs_countdown_timer.md
Name: vs_countdown_timer

Overview:
- Loadable down-counter/timer. It is the decrementing, terminal-count-producing complement to the free-running up counters.
- Software or upstream logic loads a count over a valid/ready handshake, then starts and stops it.
- Emits a one-cycle terminal-count pulse in one-shot or periodic (auto-reload) mode.
- Used for timeouts, tick generation and programmable delays.

Parameters:
N, 8, width of count, reload register and load_value.

Ports:
clock  input  1  rising-edge clock; all state updates on posedge clock.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  load_value is presented.
load_ready  output  1  timer accepts a load this cycle.
load_value  input  N  new count/reload value.
start  input  1  level-sampled request to run.
stop  input  1  level-sampled request to pause.
periodic  input  1  1 = auto-reload on terminal count; 0 = one-shot.
count  output  N  current counter value (registered).
running  output  1  state == RUN.
tc_pulse  output  1  one-cycle terminal-count strobe (registered).
expired  output  1  sticky one-shot completion flag.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset) and is checked before every other input.
- Reset values, applied on the first posedge with reset=1 and held while reset is high:
  - state = IDLE
  - count = 0, reload = 0
  - load_ready = 1, running = 0, tc_pulse = 0, expired = 0
- Reset mid-run aborts the run with no tc_pulse.
- States: IDLE (stopped, not yet run or finished), RUN (decrementing), PAUSED (stopped by stop with a count held).
- load_ready = 1 in IDLE and PAUSED, 0 in RUN. This is a combinational decode of the state register.
- Load accept (load_valid & load_ready):
  - count <= load_value, reload <= load_value, expired <= 0.
  - State is unchanged unless start is also high that cycle.
- Start, from IDLE or PAUSED with start=1 and stop=0:
  - Effective count E = load_value if a load is accepted this cycle, else count.
  - E != 0: state <= RUN, expired <= 0. The first decrement occurs on the following edge.
  - E == 0: start is ignored and the state is unchanged.
- RUN, each cycle:
  - stop=1: state <= PAUSED, count holds, no tc_pulse. stop beats everything, including count==1.
  - stop=0 and count > 1: count <= count - 1.
  - stop=0, count == 1, periodic=1: count <= reload, tc_pulse <= 1, stay RUN.
  - stop=0, count == 1, periodic=0: count <= 0, tc_pulse <= 1, expired <= 1, state <= IDLE.
- periodic is sampled live on the cycle count == 1; it is not latched at start.
- Resulting timing:
  - One-shot load L: tc_pulse rises exactly L edges after the edge that entered RUN, coincident with count == 0.
  - Periodic load L: period is L cycles. Count sequence is L, L-1, …, 1, L, …, and tc_pulse is high on the cycles where count == L after a reload.
  - Periodic with reload = 1: count stays at 1 and tc_pulse stays high every cycle while in RUN.
- tc_pulse is 0 on every cycle not listed above; it is never high for 2 cycles except the reload = 1 case.
- start while in RUN: no effect. stop while in IDLE/PAUSED: no effect.
- load_valid while in RUN: not accepted (load_ready = 0). The producer must hold its value; nothing is dropped.
- Arithmetic:
  - Count is unsigned N-bit.
  - Decrement never wraps below 0: the count == 1 branch intercepts it, and RUN is never entered with 0.
  - load_value = 2^N-1 is legal.
- Resume: start from PAUSED continues from the held count. reload is retained.

Test Plan:
1. N=8, reset, load 5, start, periodic=0 → count 5,4,3,2,1,0. tc_pulse and expired=1 at count 0, running=0, load_ready=1.
2. Load 3, periodic=1, run 10 cycles → count 3,2,1,3,2,1,3…; tc_pulse high exactly on each reload cycle (period 3).
3. Load 8, start, stop after 3 decrements → count holds 5 while PAUSED, load_ready=1. Start → resumes 4,3…; tc_pulse after 5 more edges.
4. Load and start in the same cycle with load_value=0 → count 0, state IDLE, no tc_pulse. Load 1, periodic=1 → tc_pulse high every cycle.
5. In RUN: load_valid=1 → load_ready=0, count unaffected. Stop and start together at count==1 → PAUSED, count 1, no tc_pulse.
6. Assert reset mid-RUN at count 4 → next edge count=0, running=0, tc_pulse=0, expired=0; outputs hold while reset is high.
